// File: rtl/inst_fetch.sv
// inst_fetch: program counter, req/ack instruction-memory reader and a small
// {pc, word} FIFO whose head feeds the decoder under a valid/ready handshake.
// Optional feature macro: INST_FETCH_REDIRECT_EN adds redirect_valid/redirect_pc
// and the DROP state; without it the fetch PC is strictly sequential.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
`ifdef INST_FETCH_REDIRECT_EN
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`endif
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  output logic [5:0]  op,
  output logic [5:0]  funct
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);
  localparam logic [CW:0] ONE_C   = CW1'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1
`ifdef INST_FETCH_REDIRECT_EN
    ,
    DROP = 2'd2
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_word_q [DEPTH];

  logic          push;
  logic          pop;
  logic          redir;
  logic [31:0]   redir_tgt;
  logic [CW:0]   cnt_after_pop;

`ifdef INST_FETCH_REDIRECT_EN
  logic [31:0]   drop_addr_q;

  assign redir     = redirect_valid;
  assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
`else
  assign redir     = 1'b0;
  assign redir_tgt = 32'h0000_0000;
`endif

  assign inst_valid    = (count_q != '0);
  assign pop           = inst_valid & inst_ready;
  // A redirect flushes the FIFO, so an ack landing in the same cycle is dropped.
  assign push          = (state_q == WAIT) & imem_ack & ~redir;
  assign cnt_after_pop = {1'b0, count_q} - {{CW{1'b0}}, pop};

  // Next state, fetch PC and FIFO occupancy/pointers; a redirect overrides all.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    case (state_q)
      IDLE: begin
        if (redir || (cnt_after_pop < DEPTH_C)) state_d = WAIT;
      end
      WAIT: begin
        if (imem_ack) begin
          if (!redir) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            // Only keep requesting if the word just pushed still leaves room.
            state_d    = ((cnt_after_pop + ONE_C) < DEPTH_C) ? WAIT : IDLE;
          end
        end
`ifdef INST_FETCH_REDIRECT_EN
        else if (redir) begin
          state_d = DROP;
        end
`endif
      end
`ifdef INST_FETCH_REDIRECT_EN
      // The ack retires the abandoned access even if another redirect arrives.
      DROP: begin
        if (imem_ack) state_d = WAIT;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    if (redir) begin
      fetch_pc_d = redir_tgt;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  // Control state; asynchronous reset drops imem_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
      fifo_word_q[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef INST_FETCH_REDIRECT_EN
  // Remember the address of the access being abandoned so it stays on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_addr_q <= RESET_PC;
    end else if ((state_q == WAIT) && redir && !imem_ack) begin
      drop_addr_q <= fetch_pc_q;
    end
  end

  assign imem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
`else
  assign imem_addr = fetch_pc_q;
`endif

  assign imem_req = (state_q != IDLE);

  assign inst   = inst_valid ? fifo_word_q[rd_ptr_q] : 32'h0000_0000;
  assign pc_out = inst_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0000_0000;
  assign op     = inst[31:26];
  assign funct  = inst[5:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: a scoreboard queue of {pc, word} is filled as the
// bench acks requests and checked against the FIFO head as it is presented.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic [5:0]  op;
  logic [5:0]  funct;
`ifdef INST_FETCH_REDIRECT_EN
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
`endif

  // Second instance near the top of the address space for the wrap case.
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack = 1'b0;
  logic [31:0] w_rdata = 32'h0;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [31:0] w_inst;
  logic [31:0] w_pc_out;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_pc = 32'h0000_3000;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_3000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
`ifdef INST_FETCH_REDIRECT_EN
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`endif
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .pc_out(pc_out), .op(op), .funct(funct)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata),
`ifdef INST_FETCH_REDIRECT_EN
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
`endif
    .inst_valid(w_valid), .inst_ready(w_ready),
    .inst(w_inst), .pc_out(w_pc_out), .op(w_op), .funct(w_funct)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Drive one cycle of memory/consumer inputs and update the scoreboard.
  task automatic drive(input logic ack, input logic [31:0] word,
                       input logic ready, input logic keep);
    imem_ack   = ack;
    imem_rdata = word;
    inst_ready = ready;
    if (ready && inst_valid && (sb.size() != 0)) void'(sb.pop_front());
    if (ack && imem_req && keep) begin
      sb.push_back({exp_pc, word});
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    w_ack = 1'b0; w_rdata = 32'h0; w_ready = 1'b0;
`ifdef INST_FETCH_REDIRECT_EN
    redirect_valid = 1'b0; redirect_pc = 32'h0;
`endif
    sb.delete();
    exp_pc = 32'h0000_3000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL reset_addr got %h exp 00003000", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    checks++; if ({inst, pc_out, op, funct} !== 76'h0) begin errors++; $display("FAIL reset_outputs got inst=%h pc=%h op=%h funct=%h exp all 0", inst, pc_out, op, funct); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_release_req got %b exp 0", imem_req); end
    @(posedge clk); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=00003000", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL stream_addr cyc %0d got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, exp_pc); end
      checks++; if (inst_valid !== (sb.size() != 0)) begin errors++; $display("FAIL stream_valid cyc %0d got %b exp %b", i, inst_valid, sb.size() != 0); end
      if (sb.size() != 0) begin
        checks++; if ({pc_out, inst} !== sb[0]) begin errors++; $display("FAIL stream_head cyc %0d got pc=%h inst=%h exp %h", i, pc_out, inst, sb[0]); end
      end
      drive(1'b1, 32'hA500_0000 | 32'(i), 1'b1, 1'b1);
    end
  endtask

  task automatic test_decode();
    apply_reset();
    drive(1'b1, 32'h0211_8820, 1'b1, 1'b1);
    checks++; if (inst_valid !== 1'b1 || op !== 6'h00 || funct !== 6'h20 || pc_out !== 32'h0000_3000) begin errors++; $display("FAIL decode_add got v=%b op=%h funct=%h pc=%h exp v=1 op=00 funct=20 pc=00003000", inst_valid, op, funct, pc_out); end
    drive(1'b1, 32'h3408_00FF, 1'b1, 1'b1);
    checks++; if (inst_valid !== 1'b1 || op !== 6'h0D || funct !== 6'h3F || pc_out !== 32'h0000_3004 || inst !== 32'h3408_00FF) begin errors++; $display("FAIL decode_ori got v=%b op=%h funct=%h pc=%h inst=%h exp v=1 op=0d funct=3f pc=00003004 inst=340800ff", inst_valid, op, funct, pc_out, inst); end
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    checks++; if (inst_valid !== 1'b0 || {inst, pc_out, op, funct} !== 76'h0) begin errors++; $display("FAIL decode_empty got v=%b inst=%h pc=%h op=%h funct=%h exp all 0", inst_valid, inst, pc_out, op, funct); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3008) begin errors++; $display("FAIL decode_next_addr got req=%b addr=%h exp req=1 addr=00003008", imem_req, imem_addr); end
  endtask

  task automatic test_backpressure();
    int reqs;
    apply_reset();
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req === 1'b1) reqs++;
      drive(1'b1, 32'hB000_0000 | 32'(i), 1'b0, 1'b1);
    end
    checks++; if (reqs !== 2) begin errors++; $display("FAIL bp_fill_reqs got %0d exp 2", reqs); end
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin errors++; $display("FAIL bp_full got req=%b valid=%b exp req=0 valid=1", imem_req, inst_valid); end
    checks++; if ({pc_out, inst} !== sb[0]) begin errors++; $display("FAIL bp_head_full got pc=%h inst=%h exp %h", pc_out, inst, sb[0]); end
    drive(1'b1, 32'hBEEF_0000, 1'b1, 1'b1);
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req === 1'b1) begin
        reqs++;
        checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL bp_refill_addr got %h exp %h", imem_addr, exp_pc); end
      end
      drive(1'b1, 32'hC000_0000 | 32'(i), 1'b0, 1'b1);
    end
    checks++; if (reqs !== 1) begin errors++; $display("FAIL bp_refill_reqs got %0d exp 1", reqs); end
    checks++; if (imem_req !== 1'b0 || {pc_out, inst} !== sb[0]) begin errors++; $display("FAIL bp_after_pop got req=%b pc=%h inst=%h exp req=0 %h", imem_req, pc_out, inst, sb[0]); end
  endtask

  task automatic test_delayed_ack();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL delay_stable cyc %0d got req=%b addr=%h exp req=1 addr=00003000", i, imem_req, imem_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL delay_valid_early cyc %0d got %b exp 0", i, inst_valid); end
      if (i < 3) drive(1'b0, 32'h0, 1'b0, 1'b1);
      else       drive(1'b1, 32'hD00D_1234, 1'b0, 1'b1);
    end
    checks++; if (inst_valid !== 1'b1 || {pc_out, inst} !== sb[0]) begin errors++; $display("FAIL delay_head got v=%b pc=%h inst=%h exp v=1 %h", inst_valid, pc_out, inst, sb[0]); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3004) begin errors++; $display("FAIL delay_next got req=%b addr=%h exp req=1 addr=00003004", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1'b1, 32'hE000_0001, 1'b0, 1'b1);
    checks++; if (inst_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h0000_3004) begin errors++; $display("FAIL rmid_pre got v=%b req=%b addr=%h exp v=1 req=1 addr=00003004", inst_valid, imem_req, imem_addr); end
    imem_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_async got req=%b valid=%b exp 0 0", imem_req, inst_valid); end
    checks++; if (imem_addr !== 32'h0000_3000 || inst !== 32'h0) begin errors++; $display("FAIL rmid_addr got addr=%h inst=%h exp 00003000 0", imem_addr, inst); end
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    sb.delete();
    exp_pc = 32'h0000_3000;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale got valid=%b exp 0", inst_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL rmid_restart got req=%b addr=%h exp req=1 addr=00003000", imem_req, imem_addr); end
    drive(1'b1, 32'h1111_2222, 1'b0, 1'b1);
    checks++; if (inst_valid !== 1'b1 || {pc_out, inst} !== sb[0]) begin errors++; $display("FAIL rmid_first got v=%b pc=%h inst=%h exp v=1 %h", inst_valid, pc_out, inst, sb[0]); end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      e = 32'hFFFF_FFF8 + 32'(4 * i);
      checks++; if (w_req !== 1'b1 || w_addr !== e) begin errors++; $display("FAIL wrap_addr cyc %0d got req=%b addr=%h exp req=1 addr=%h", i, w_req, w_addr, e); end
      if (i > 0) begin
        checks++; if (w_valid !== 1'b1 || w_pc_out !== e - 32'd4 || w_inst !== 32'(i - 1)) begin errors++; $display("FAIL wrap_head cyc %0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", i, w_valid, w_pc_out, w_inst, e - 32'd4, 32'(i - 1)); end
      end
      w_ack = 1'b1; w_rdata = 32'(i); w_ready = 1'b1;
      @(posedge clk); #1;
    end
    w_ack = 1'b0; w_ready = 1'b0;
  endtask

`ifdef INST_FETCH_REDIRECT_EN
  task automatic test_redirect();
    apply_reset();
    drive(1'b1, 32'hF000_0000, 1'b1, 1'b1);
    drive(1'b1, 32'hF000_0004, 1'b1, 1'b1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3008 || inst_valid !== 1'b1) begin errors++; $display("FAIL redir_pre got req=%b addr=%h v=%b exp req=1 addr=00003008 v=1", imem_req, imem_addr, inst_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_4003;
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    redirect_valid = 1'b0;
    sb.delete();
    exp_pc = 32'h0000_4000;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got valid=%b exp 0", inst_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3008) begin errors++; $display("FAIL redir_drop_addr got req=%b addr=%h exp req=1 addr=00003008", imem_req, imem_addr); end
    drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_dropped got valid=%b exp 0", inst_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_4000) begin errors++; $display("FAIL redir_new_addr got req=%b addr=%h exp req=1 addr=00004000", imem_req, imem_addr); end
    drive(1'b1, 32'h0000_4444, 1'b0, 1'b1);
    checks++; if (inst_valid !== 1'b1 || {pc_out, inst} !== sb[0]) begin errors++; $display("FAIL redir_head got v=%b pc=%h inst=%h exp v=1 %h", inst_valid, pc_out, inst, sb[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_decode();
    test_backpressure();
    test_delayed_ack();
    test_reset_mid();
    test_wrap();
`ifdef INST_FETCH_REDIRECT_EN
    test_redirect();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
